// File: rtl/sw_param_loader.sv
// sw_param_loader
// Latches two 7-bit switch banks (floors, resistance) into 32-bit
// zero-extended initialisation outputs when a debounced load pushbutton is
// pressed, then issues a registered restart pulse to the CPU core.
//
// Ports:
//   in_clk              - single rising-edge clock
//   in_rst              - synchronous, active-high reset
//   in_floors_sw[6:0]   - asynchronous floors switch bank
//   in_resistance_sw[6:0] - asynchronous resistance switch bank
//   in_load_btn         - asynchronous, bouncing load pushbutton (active-high)
//   out_init_floors[31:0]     - latched floors value, zero-extended
//   out_init_resistance[31:0] - latched resistance value, zero-extended
//   out_cpu_rst         - restart pulse, RST_CYCLES cycles long per load
//   out_valid           - set once the first load has been accepted
//   out_err             - one-cycle pulse when a load is rejected
//
// Optional feature: define PARAM_RANGE_CHECK_EN to reject loads where either
// switch bank reads zero. Without it every value is accepted and out_err is
// tied low.
//
// DEBOUNCE_CYCLES and RST_CYCLES are expected to be >= 1.

module sw_param_loader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RST_CYCLES      = 16
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [6:0]  in_floors_sw,
  input  logic [6:0]  in_resistance_sw,
  input  logic        in_load_btn,
  output logic [31:0] out_init_floors,
  output logic [31:0] out_init_resistance,
  output logic        out_cpu_rst,
  output logic        out_valid,
  output logic        out_err
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DEB      = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Two-flop synchronizers for every asynchronous input
  logic        r_sync1_btn, r_sync2_btn;
  logic [6:0]  r_sync1_floors, r_sync2_floors;
  logic [6:0]  r_sync1_res, r_sync2_res;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt, w_hold_cnt_nxt;
  logic [6:0]          r_floors, w_floors_nxt;
  logic [6:0]          r_res, w_res_nxt;
  logic                r_cpu_rst, w_cpu_rst_nxt;
  logic                r_valid, w_valid_nxt;
  logic                w_reject;

`ifdef PARAM_RANGE_CHECK_EN
  // Reject decision is taken when the banks are sampled and acted on in LOAD
  logic                r_reject, w_reject_nxt;
  logic                r_err, w_err_nxt;
  assign w_reject = (r_sync2_floors == 7'd0) || (r_sync2_res == 7'd0);
`else
  assign w_reject = 1'b0;
`endif

  // Input synchronizer chain
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_sync1_btn    <= 1'b0;
      r_sync2_btn    <= 1'b0;
      r_sync1_floors <= 7'd0;
      r_sync2_floors <= 7'd0;
      r_sync1_res    <= 7'd0;
      r_sync2_res    <= 7'd0;
    end else begin
      r_sync1_btn    <= in_load_btn;
      r_sync2_btn    <= r_sync1_btn;
      r_sync1_floors <= in_floors_sw;
      r_sync2_floors <= r_sync1_floors;
      r_sync1_res    <= in_resistance_sw;
      r_sync2_res    <= r_sync1_res;
    end
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hold_cnt <= '0;
      r_floors   <= 7'd0;
      r_res      <= 7'd0;
      r_cpu_rst  <= 1'b0;
      r_valid    <= 1'b0;
`ifdef PARAM_RANGE_CHECK_EN
      r_reject   <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_floors   <= w_floors_nxt;
      r_res      <= w_res_nxt;
      r_cpu_rst  <= w_cpu_rst_nxt;
      r_valid    <= w_valid_nxt;
`ifdef PARAM_RANGE_CHECK_EN
      r_reject   <= w_reject_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_floors_nxt   = r_floors;
    w_res_nxt      = r_res;
    w_cpu_rst_nxt  = 1'b0;
    w_valid_nxt    = r_valid;
`ifdef PARAM_RANGE_CHECK_EN
    w_reject_nxt   = r_reject;
    w_err_nxt      = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (r_sync2_btn) begin
          w_state_nxt = ST_PRESS;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end

      ST_PRESS: begin
        if (!r_sync2_btn) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_DEB) begin
          // Banks are captured on the edge that enters LOAD so the outputs
          // update DEBOUNCE_CYCLES+2 edges after the button is first sampled.
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = '0;
`ifdef PARAM_RANGE_CHECK_EN
          w_reject_nxt = w_reject;
`endif
          if (!w_reject) begin
            w_floors_nxt = r_sync2_floors;
            w_res_nxt    = r_sync2_res;
          end else begin
            w_floors_nxt = r_floors;
            w_res_nxt    = r_res;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      ST_LOAD: begin
        w_cnt_nxt      = '0;
        w_hold_cnt_nxt = '0;
`ifdef PARAM_RANGE_CHECK_EN
        if (r_reject) begin
          w_state_nxt = ST_RELEASE;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt   = ST_HOLD;
          w_cpu_rst_nxt = 1'b1;
          w_valid_nxt   = 1'b1;
        end
`else
        w_state_nxt   = ST_HOLD;
        w_cpu_rst_nxt = 1'b1;
        w_valid_nxt   = 1'b1;
`endif
      end

      ST_HOLD: begin
        // The pulse was raised on entry; it stays up for RST_CYCLES edges.
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt    = ST_RELEASE;
          w_hold_cnt_nxt = '0;
          w_cnt_nxt      = '0;
          w_cpu_rst_nxt  = 1'b0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
          w_cpu_rst_nxt  = 1'b1;
        end
      end

      ST_RELEASE: begin
        // Any high sample restarts the low-time count, so a held button
        // can never re-arm a load.
        if (r_sync2_btn) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_DEB_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign out_init_floors     = {25'd0, r_floors};
  assign out_init_resistance = {25'd0, r_res};
  assign out_cpu_rst         = r_cpu_rst;
  assign out_valid           = r_valid;
`ifdef PARAM_RANGE_CHECK_EN
  assign out_err             = r_err;
`else
  assign out_err             = 1'b0;
`endif

endmodule

// File: tb/tb_sw_param_loader.sv
// Testbench for sw_param_loader (DEBOUNCE_CYCLES=4, RST_CYCLES=3).
// Expected behaviour is derived from edge arithmetic: a button run of n
// sampled-high edges starting at edge k loads iff n >= D+1, the outputs
// change at edge k+D+2 and the restart pulse covers edges k+D+3..k+D+2+R.

module tb_sw_param_loader;

  localparam int D = 4;
  localparam int R = 3;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_load_btn;
  logic [6:0]  in_floors_sw;
  logic [6:0]  in_resistance_sw;
  logic [31:0] out_init_floors;
  logic [31:0] out_init_resistance;
  logic        out_cpu_rst;
  logic        out_valid;
  logic        out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0] m_floors;
  logic [6:0] m_res;
  logic       m_valid;

  sw_param_loader #(
    .DEBOUNCE_CYCLES(D),
    .RST_CYCLES(R)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_floors_sw(in_floors_sw),
    .in_resistance_sw(in_resistance_sw),
    .in_load_btn(in_load_btn),
    .out_init_floors(out_init_floors),
    .out_init_resistance(out_init_resistance),
    .out_cpu_rst(out_cpu_rst),
    .out_valid(out_valid),
    .out_err(out_err)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge in_clk);
    @(negedge in_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_rst, input logic exp_err);
    chk({tag, "_floors"}, out_init_floors, {25'd0, m_floors});
    chk({tag, "_res"}, out_init_resistance, {25'd0, m_res});
    chk({tag, "_cpu_rst"}, {31'd0, out_cpu_rst}, {31'd0, exp_rst});
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
  endtask

  // Hold the button for n_high edges starting at the next edge, run n_total
  // edges, optionally pulse reset at edge k+rst_off, optionally scramble the
  // switches once they can no longer be captured.
  task automatic run_pulse(input string tag, input int n_high, input int n_total,
                           input logic [6:0] fl, input logic [6:0] rs,
                           input int rst_off, input bit scramble);
    int  k;
    int  e;
    int  er;
    bit  has_rst;
    bit  load;
    bit  rej;
    bit  exp_rst;
    bit  exp_err;
    k       = cyc + 1;
    has_rst = (rst_off > 0);
    er      = k + rst_off;
    load    = (n_high >= D + 1);
`ifdef PARAM_RANGE_CHECK_EN
    rej     = load && ((fl == 7'd0) || (rs == 7'd0));
`else
    rej     = 1'b0;
`endif
    in_floors_sw     = fl;
    in_resistance_sw = rs;
    for (int i = 0; i < n_total; i++) begin
      in_load_btn = (i < n_high) && (!has_rst || (cyc + 1 < er));
      in_rst      = has_rst && (cyc + 1 == er);
      if (scramble && (i >= D + 3)) begin
        in_floors_sw     = 7'($urandom);
        in_resistance_sw = 7'($urandom);
      end
      tick();
      e = cyc;
      if (load && !rej && (e == k + D + 2)) begin
        m_floors = fl;
        m_res    = rs;
      end
      if (load && !rej && (e == k + D + 3)) begin
        m_valid = 1'b1;
      end
      if (has_rst && (e == er)) begin
        m_floors = 7'd0;
        m_res    = 7'd0;
        m_valid  = 1'b0;
      end
      exp_rst = load && !rej && (e >= k + D + 3) && (e <= k + D + 2 + R) &&
                (!has_rst || (e < er));
      exp_err = rej && (e == k + D + 3);
      chk_all(tag, exp_rst, exp_err);
    end
    in_load_btn = 1'b0;
    in_rst      = 1'b0;
  endtask

  initial begin
    in_rst           = 1'b1;
    in_load_btn      = 1'b0;
    in_floors_sw     = 7'd0;
    in_resistance_sw = 7'd0;
    m_floors         = 7'd0;
    m_res            = 7'd0;
    m_valid          = 1'b0;

    // Reset state
    repeat (3) begin
      tick();
      chk_all("reset", 1'b0, 1'b0);
    end
    in_rst = 1'b0;
    while (cyc < 9) begin
      tick();
      chk_all("idle", 1'b0, 1'b0);
    end

    // Clean press: button first sampled at edge 10
    run_pulse("clean", 12, 30, 7'd100, 7'd35, 0, 1'b0);
    chk("clean_floors_abs", out_init_floors, 32'd100);
    chk("clean_res_abs", out_init_resistance, 32'd35);

    // Bounce: 3 high, 1 low, 3 high, never debounced
    run_pulse("bounce_a", 3, 4, 7'd55, 7'd66, 0, 1'b0);
    run_pulse("bounce_b", 3, 25, 7'd55, 7'd66, 0, 1'b0);
    chk("bounce_floors_abs", out_init_floors, 32'd100);

    // Held button with switches changing after capture
    run_pulse("held", 50, 75, 7'd42, 7'd17, 0, 1'b1);
    chk("held_floors_abs", out_init_floors, 32'd42);

    // Reset on the second restart-pulse cycle
    run_pulse("rst_hold", 20, 40, 7'd9, 7'd10, D + 5, 1'b0);
    chk("rst_hold_valid_abs", {31'd0, out_valid}, 32'd0);

    // Fresh press after reset, then a re-press with floors=1
    run_pulse("fresh", 10, 30, 7'd77, 7'd88, 0, 1'b0);
    run_pulse("repress", 10, 30, 7'd1, 7'd20, 0, 1'b0);
    chk("repress_floors_abs", out_init_floors, 32'd1);

    // Zero bank press (rejected only when range checking is built in)
    run_pulse("zero_bank", 10, 30, 7'd0, 7'd5, 0, 1'b0);

    // Randomized presses of random length
    for (int n = 0; n < 8; n++) begin
      int nh;
      nh = int'($urandom_range(1, 10));
      run_pulse("rand", nh, nh + 25, 7'($urandom), 7'($urandom), 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_param_loader.md
SW_PARAM_LOADER -- requirements
Module: sw_param_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a button level change.
REQ-002 Parameter RST_CYCLES, default 16: cycles out_cpu_rst is held high after a load.
REQ-003 One clock; reset is synchronous and active-high; the ports are in_clk and in_rst.
REQ-004 in_clk  input  1: single clock; all logic is rising-edge.
REQ-005 in_rst  input  1: synchronous, active-high reset.
REQ-006 in_floors_sw  input  7: asynchronous floors switch bank.
REQ-007 in_resistance_sw  input  7: asynchronous resistance switch bank.
REQ-008 in_load_btn  input  1: asynchronous, bouncing load pushbutton, active-high.
REQ-009 out_init_floors  output  32: latched floors value, zero-extended.
REQ-010 out_init_resistance  output  32: latched resistance value, zero-extended.
REQ-011 out_cpu_rst  output  1: registered restart pulse to the CPU core.
REQ-012 out_valid  output  1: high once at least one load has been accepted.
REQ-013 out_err  output  1: one-cycle pulse when a load is rejected.

Function
REQ-014 All 15 asynchronous inputs SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-015 The FSM SHALL have states IDLE, PRESS, LOAD, HOLD, RELEASE, using a debounce counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-016 IDLE: sync2 button=1 -> PRESS with counter=1; otherwise stay in IDLE with counter=0.
REQ-017 PRESS: sync2=0 -> IDLE with counter cleared; sync2=1 with counter==DEBOUNCE_CYCLES -> LOAD; otherwise counter+1.
REQ-018 LOAD (one cycle): capture sync2 switch banks into the outputs, zero-extended in bits [31:7], then -> HOLD with counter=0.
REQ-019 HOLD: out_cpu_rst SHALL be 1 for exactly RST_CYCLES consecutive cycles, then 0, then -> RELEASE.
REQ-020 RELEASE: -> IDLE after DEBOUNCE_CYCLES consecutive cycles with sync2 button=0; any 1 restarts the count.
REQ-021 Button presses during LOAD, HOLD or RELEASE SHALL NOT trigger a second load; exactly one load occurs per debounced press.
REQ-022 Latency: if in_load_btn is first sampled high at edge k and stays high, outputs update at edge k+DEBOUNCE_CYCLES+2, and out_cpu_rst is high for edges k+DEBOUNCE_CYCLES+3 through k+DEBOUNCE_CYCLES+2+RST_CYCLES.
REQ-023 Switch changes outside the LOAD cycle SHALL NOT alter out_init_*.
REQ-024 out_valid SHALL go to 1 in the cycle after the first accepted LOAD and hold until reset.
REQ-025 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no load, no restart pulse and no output change.

Reset
REQ-026 in_rst=1 at an edge SHALL force: state IDLE, counter 0, synchronizers 0, out_init_floors=0, out_init_resistance=0, out_cpu_rst=0, out_valid=0, out_err=0.
REQ-027 Reset asserted during HOLD SHALL drop out_cpu_rst at the next edge; a load in progress is discarded.

Configuration
REQ-028 Macro PARAM_RANGE_CHECK_EN defined: a LOAD SHALL be rejected if either captured bank equals 0. On rejection, outputs and out_valid are unchanged, out_err pulses for exactly 1 cycle, HOLD is skipped, and the FSM goes directly to RELEASE.
REQ-029 Macro PARAM_RANGE_CHECK_EN undefined: all values are accepted, out_err is tied 0, and no check logic is synthesized.

Verification (DEBOUNCE_CYCLES=4, RST_CYCLES=3)
REQ-030 Clean press: floors=7'd100, resistance=7'd35, button high from edge 10 -> out_init_floors=32'd100 and out_init_resistance=32'd35 at edge 16; out_cpu_rst high at edges 17-19; out_valid=1 from edge 17.
REQ-031 Bounce: button high for 3 cycles, low for 1, high for 3 -> no output change, out_cpu_rst stays 0.
REQ-032 Held button: button held for 50 cycles with switches changing after LOAD -> exactly one out_cpu_rst pulse of 3 cycles; outputs keep the LOAD-cycle values.
REQ-033 Reset mid-HOLD: in_rst=1 on the second out_cpu_rst cycle -> next edge all outputs 0, state IDLE; a fresh press then loads normally.
REQ-034 With PARAM_RANGE_CHECK_EN: floors=0, resistance=5, press -> out_err 1-cycle pulse, out_cpu_rst stays 0, out_init_* and out_valid unchanged.
REQ-035 Re-press: after full release (4 low cycles), a second press with floors=1 -> second load, out_init_floors=32'd1 and a second 3-cycle restart pulse.
